dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding 64-bit data memory responder with fixed access latency
// Build with DMEM_ERRCNT_EN defined to get a saturating count of error responses on err_count.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error,
  output logic [15:0] err_count
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [63:0] r_rdata;
  logic        r_error;
  logic [63:0] r_mem [DEPTH] = '{default: '0};

  logic        w_accept;
  logic        w_commit;
  logic        w_hs;
  logic        w_write;
  logic        w_err;
  logic [63:0] w_addr;
  logic [63:0] w_wdata;

  // With LATENCY = 1 the commit edge is the accept edge, so take the live request fields.
  assign w_write = (r_state == S_IDLE) ? req_write : r_write;
  assign w_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
  assign w_err   = (w_addr >= 64'(DEPTH));

  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    w_hs         = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          if (LATENCY == 1) begin
            w_commit     = 1'b1;
            w_next_state = S_RESP;
          end else begin
            w_next_state = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (r_cnt == 4'd0) begin
          w_commit     = 1'b1;
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_hs         = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_addr  <= 64'd0;
      r_wdata <= 64'd0;
      r_rdata <= 64'd0;
      r_error <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_cnt   <= CNT_LOAD;
      end else if (r_state == S_BUSY && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_error <= w_err;
        r_rdata <= (w_write || w_err) ? 64'd0 : r_mem[w_addr[AW-1:0]];
      end
    end
  end

  // Memory contents survive reset; only the commit edge may write.
  always_ff @(posedge clk) begin
    if (!reset && w_commit && w_write && !w_err) begin
      r_mem[w_addr[AW-1:0]] <= w_wdata;
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_error = r_error;

`ifdef DMEM_ERRCNT_EN
  logic [15:0] r_err_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_count <= 16'd0;
    end else if (w_hs && r_error && r_err_count != 16'hFFFF) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = 16'd0;
`endif

endmodule
